// File: rtl/wr_burst_packer.sv
// Write-side packer: buffers a user beat stream in a FWFT FIFO and forwards it
// as AXI-legal bursts (<= BURST_LEN beats, never crossing a 4 KB page).
module wr_burst_packer #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int BURST_LEN  = 256,
   parameter int FIFO_DEPTH = 4096,
   parameter int LEN_W      = 16,
   parameter int AF_MARGIN  = 96
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [ADDR_W-1:0]             cmd_addr,
   input  logic [LEN_W-1:0]              cmd_len,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          bst_valid,
   input  logic                          bst_ready,
   output logic [ADDR_W-1:0]             bst_addr,
   output logic [7:0]                    bst_len,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_last,
   output logic                          done,
   output logic                          busy,
   output logic                          almost_full,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   // state       | meaning
   // S_IDLE      | waiting for a command, cmd_ready high
   // S_CALC      | size next burst from remaining beats, BURST_LEN and page room
   // S_WAIT_DATA | hold until the whole burst is buffered
   // S_CMD       | present burst command until accepted
   // S_DATA      | stream the burst's beats
   // S_DONE      | one-cycle completion pulse

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int BSH = $clog2(DATA_W / 8);
   localparam int CW  = (LEN_W + 1 > 13) ? LEN_W + 1 : 13;

   typedef enum logic [2:0] {
      S_IDLE, S_CALC, S_WAIT_DATA, S_CMD, S_DATA, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              wr_en, rd_en;
   logic [LW-1:0]     level_nxt;

   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  rem;
   logic [8:0]        nb, beat_cnt;
   logic [12:0]       page_beats;
   logic [CW-1:0]     nb_calc;
   logic              last_beat;

   assign in_ready = (level != LW'(FIFO_DEPTH));
   assign wr_en    = in_valid && in_ready;
   assign rd_en    = out_valid && out_ready;

   always_comb begin
      level_nxt = level;
      if (wr_en && !rd_en)
         level_nxt = level + LW'(1);
      else if (rd_en && !wr_en)
         level_nxt = level - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         almost_full <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + AW'(1);
         level       <= level_nxt;
         almost_full <= (LW'(FIFO_DEPTH) - level_nxt) < LW'(AF_MARGIN);
      end
   end

   // Burst size: smallest of remaining beats, BURST_LEN and beats left in the page.
   always_comb begin
      page_beats = (13'd4096 - {1'b0, cur_addr[11:0]}) >> BSH;
      nb_calc    = CW'(rem);
      if (CW'(BURST_LEN) < nb_calc)
         nb_calc = CW'(BURST_LEN);
      if (CW'(page_beats) < nb_calc)
         nb_calc = CW'(page_beats);
   end

   assign last_beat = (beat_cnt == nb - 9'd1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (cmd_valid) state_nxt = (cmd_len == '0) ? S_DONE : S_CALC;
         S_CALC:      state_nxt = S_WAIT_DATA;
         S_WAIT_DATA: if (level >= LW'(nb)) state_nxt = S_CMD;
         S_CMD:       if (bst_ready) state_nxt = S_DATA;
         S_DATA:      if (rd_en && last_beat)
                         state_nxt = (rem != LEN_W'(nb)) ? S_CALC : S_DONE;
         S_DONE:      state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cur_addr <= '0;
         rem      <= '0;
         nb       <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (cmd_valid) begin
               cur_addr <= cmd_addr;
               rem      <= cmd_len;
            end
            S_CALC: begin
               nb       <= 9'(nb_calc);
               beat_cnt <= '0;
            end
            S_DATA: if (rd_en) begin
               beat_cnt <= beat_cnt + 9'd1;
               if (last_beat) begin
                  rem      <= rem - LEN_W'(nb);
                  cur_addr <= cur_addr + (ADDR_W'(nb) << BSH);
               end
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign bst_valid = (state == S_CMD);
   assign bst_addr  = bst_valid ? cur_addr : '0;
   assign bst_len   = bst_valid ? 8'(nb - 9'd1) : '0;
   assign out_valid = (state == S_DATA) && (beat_cnt < nb);
   assign out_last  = out_valid && last_beat;
   // Gated so the stale memory word never shows outside a data phase.
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_wr_burst_packer.sv
// Bench for wr_burst_packer: random data, directed commands, scoreboard of
// expected beats and bursts derived from the page/burst splitting rules.
module tb_wr_burst_packer;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 64;
   localparam int BURST_LEN  = 256;
   localparam int FIFO_DEPTH = 4096;
   localparam int LEN_W      = 16;
   localparam int AF_MARGIN  = 96;
   localparam int BYTES      = DATA_W / 8;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              cmd_valid, cmd_ready;
   logic [31:0]       cmd_addr;
   logic [15:0]       cmd_len;
   logic              in_valid, in_ready;
   logic [63:0]       in_data;
   logic              bst_valid, bst_ready;
   logic [31:0]       bst_addr;
   logic [7:0]        bst_len;
   logic              out_valid, out_ready, out_last;
   logic [63:0]       out_data;
   logic              done, busy, almost_full;
   logic [12:0]       level;

   wr_burst_packer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
      .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W), .AF_MARGIN(AF_MARGIN)
   ) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .bst_valid(bst_valid), .bst_ready(bst_ready), .bst_addr(bst_addr), .bst_len(bst_len),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .done(done), .busy(busy), .almost_full(almost_full), .level(level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } burst_t;

   logic [63:0] exp_q[$];
   burst_t      bq[$];
   burst_t      seen_q[$];
   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          cur_left = 0;
   int          acc_cyc = 0;
   int          bst_wait = 0;
   bit          mbusy = 0, exp_done = 0, exp_done_nxt = 0, lat_armed = 0, last_in_hs = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference split: walk the transfer in page/BURST_LEN-limited chunks.
   task automatic plan(input logic [31:0] addr, input int len);
      logic [31:0] a;
      int r, page, n;
      burst_t b;
      a = addr;
      r = len;
      while (r > 0) begin
         page = (4096 - int'(a[11:0])) / BYTES;
         n = r;
         if (n > BURST_LEN) n = BURST_LEN;
         if (n > page) n = page;
         b.addr = a;
         b.len  = 8'(n - 1);
         bq.push_back(b);
         a = a + 32'(n * BYTES);
         r -= n;
      end
   endtask

   // One clock: check visible state against the model, book this cycle's handshakes.
   task automatic tick();
      bit in_hs, out_hs, bst_hs;
      burst_t b;
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("almost_full", almost_full, (FIFO_DEPTH - exp_q.size()) < AF_MARGIN);
      chk("in_ready", in_ready, exp_q.size() != FIFO_DEPTH);
      chk("cmd_ready", cmd_ready, !mbusy);
      chk("busy", busy, mbusy);
      chk("done", done, exp_done);
      if (bst_valid) begin
         if (cur_left != 0 || bq.size() == 0)
            chk("bst_unexpected", bst_valid, 1'b0);
         else begin
            chk("bst_addr", bst_addr, bq[0].addr);
            chk("bst_len", bst_len, bq[0].len);
         end
         if (lat_armed) begin
            chk("cmd_to_bst_latency", 64'(cyc - acc_cyc), 64'd3);
            lat_armed = 0;
         end
      end
      if (cur_left == 0 || exp_q.size() == 0)
         chk("out_unexpected", out_valid, 1'b0);
      else if (out_valid) begin
         chk("out_data", out_data, exp_q[0]);
         chk("out_last", out_last, cur_left == 1);
      end
      in_hs  = in_valid && in_ready;
      out_hs = out_valid && out_ready && cur_left != 0 && exp_q.size() != 0;
      bst_hs = bst_valid && bst_ready && cur_left == 0 && bq.size() != 0;
      if (cmd_valid && cmd_ready) begin
         mbusy = 1;
         seen_q.delete();
         bq.delete();
         plan(cmd_addr, int'(cmd_len));
         acc_cyc = cyc;
         if (cmd_len == 16'd0)
            exp_done_nxt = 1;
         else
            lat_armed = (exp_q.size() >= int'(bq[0].len) + 1);
      end
      if (out_hs) begin
         void'(exp_q.pop_front());
         cur_left--;
         if (cur_left == 0 && bq.size() == 0)
            exp_done_nxt = 1;
      end
      if (bst_hs) begin
         cur_left = int'(bq[0].len) + 1;
         b.addr = bst_addr;
         b.len  = bst_len;
         seen_q.push_back(b);
         void'(bq.pop_front());
      end
      if (in_hs)
         exp_q.push_back(in_data);
      if (bst_valid && !bst_ready) bst_wait++;
      else bst_wait = 0;
      if (exp_done) mbusy = 0;
      exp_done = exp_done_nxt;
      exp_done_nxt = 0;
      last_in_hs = in_hs;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic preload(input int n);
      int pushed, guard;
      pushed = 0;
      guard = 0;
      cmd_valid = 0; out_ready = 0; bst_ready = 0;
      while (pushed < n && guard < n + 100) begin
         in_valid = 1;
         in_data = {$urandom, $urandom};
         tick();
         if (last_in_hs) pushed++;
         guard++;
      end
      in_valid = 0;
      chk("preload_count", 64'(pushed), 64'(n));
   endtask

   task automatic issue(input logic [31:0] a, input logic [15:0] l);
      int g;
      g = 0;
      cmd_valid = 1; cmd_addr = a; cmd_len = l;
      in_valid = 0; out_ready = 0; bst_ready = 0;
      while (!mbusy && g < 10) begin
         tick();
         g++;
      end
      cmd_valid = 0;
      chk("cmd_accepted", busy, 1'b1);
   endtask

   task automatic run(input int out_pct, input int in_pct, input int feed, input int hold);
      int n, left;
      n = 0;
      left = feed;
      while (mbusy && n < 12000) begin
         out_ready = ($urandom_range(0, 99) < out_pct);
         in_valid  = (left > 0) && ($urandom_range(0, 99) < in_pct);
         in_data   = {$urandom, $urandom};
         bst_ready = bst_valid && (bst_wait >= hold);
         cmd_valid = !exp_done && ($urandom_range(0, 3) == 0);
         cmd_addr  = $urandom;
         cmd_len   = 16'($urandom_range(0, 50));
         tick();
         n++;
         if (last_in_hs) left--;
      end
      cmd_valid = 0; in_valid = 0; out_ready = 0; bst_ready = 0;
      chk("run_idle", busy, 1'b0);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int l, f, g;
      cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
      in_valid = 0; in_data = '0; bst_ready = 0; out_ready = 0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_bst_valid", bst_valid, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_almost_full", almost_full, 1'b0);
      resetn = 1;
      tick();

      // aligned, two full bursts
      preload(512);
      issue(32'h1000, 16'd512);
      run(100, 0, 0, 0);
      chk("aligned_nbursts", 64'(seen_q.size()), 64'd2);
      if (seen_q.size() == 2) begin
         chk("aligned_b0_addr", seen_q[0].addr, 32'h1000);
         chk("aligned_b0_len", seen_q[0].len, 8'd255);
         chk("aligned_b1_addr", seen_q[1].addr, 32'h1800);
         chk("aligned_b1_len", seen_q[1].len, 8'd255);
      end

      // short tail
      preload(300);
      issue(32'h0, 16'd300);
      run(70, 0, 0, 0);
      chk("tail_nbursts", 64'(seen_q.size()), 64'd2);
      if (seen_q.size() == 2) begin
         chk("tail_b1_addr", seen_q[1].addr, 32'h800);
         chk("tail_b1_len", seen_q[1].len, 8'd43);
      end
      chk("tail_level", 64'(level), 64'd0);

      // 4 KB split
      preload(64);
      issue(32'h0F80, 16'd64);
      run(100, 0, 0, 0);
      chk("split_nbursts", 64'(seen_q.size()), 64'd2);
      if (seen_q.size() == 2) begin
         chk("split_b0_len", seen_q[0].len, 8'd15);
         chk("split_b1_addr", seen_q[1].addr, 32'h1000);
         chk("split_b1_len", seen_q[1].len, 8'd47);
      end

      // full FIFO, then drain with one large command
      preload(FIFO_DEPTH);
      out_ready = 0; bst_ready = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1;
         in_data = {$urandom, $urandom};
         tick();
      end
      in_valid = 0;
      chk("full_in_ready", in_ready, 1'b0);
      chk("full_almost_full", almost_full, 1'b1);
      chk("full_level", 64'(level), 64'd4096);
      issue(32'h0, 16'd4096);
      run(100, 0, 0, 0);
      chk("full_nbursts", 64'(seen_q.size()), 64'd16);
      if (seen_q.size() == 16)
         chk("full_b15_addr", seen_q[15].addr, 32'h7800);
      chk("full_drained", 64'(level), 64'd0);

      // zero-length command
      issue(32'h40, 16'd0);
      run(100, 0, 0, 0);
      chk("len0_no_burst", 64'(seen_q.size()), 64'd0);

      // backpressure with concurrent input; 5 beats left over
      issue(32'h2F00, 16'd200);
      run(50, 60, 205, 10);
      chk("bp_nbursts", 64'(seen_q.size()), 64'd2);
      chk("bp_leftover", 64'(level), 64'd5);

      // random commands including address wrap
      for (int i = 0; i < 5; i++) begin
         a = $urandom & 32'hFFFF_FFF8;
         if (i == 0)
            a = 32'hFFFF_FF00;
         else if (i % 2 == 1)
            a = (a & 32'hFFFF_F000) | (32'h0000_0FF8 - 32'(8 * $urandom_range(0, 40)));
         l = $urandom_range(1, 600);
         f = (l > exp_q.size()) ? l - exp_q.size() : 0;
         f += $urandom_range(0, 6);
         issue(a, 16'(l));
         run($urandom_range(30, 100), $urandom_range(30, 100), f, $urandom_range(0, 3));
      end

      // reset in the middle of a data phase
      preload(40);
      issue(32'h0, 16'd40);
      g = 0;
      out_ready = 1;
      while (!(cur_left != 0 && cur_left < 30) && g < 200) begin
         bst_ready = bst_valid;
         tick();
         g++;
      end
      chk("reached_data_phase", out_valid, 1'b1);
      #2 resetn = 0;
      #1;
      chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_bst_valid", bst_valid, 1'b0);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_out_last", out_last, 1'b0);
      chk("mid_rst_out_data", out_data, 64'd0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_level", 64'(level), 64'd0);
      chk("mid_rst_almost_full", almost_full, 1'b0);
      exp_q.delete(); bq.delete(); seen_q.delete();
      cur_left = 0; mbusy = 0; exp_done = 0; exp_done_nxt = 0; lat_armed = 0; bst_wait = 0;
      cmd_valid = 0; in_valid = 0; out_ready = 0; bst_ready = 0;
      @(negedge clk);
      resetn = 1;
      tick();
      tick();
      preload(8);
      issue(32'h100, 16'd8);
      run(100, 0, 0, 0);
      chk("recover_nbursts", 64'(seen_q.size()), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/wr_burst_packer.md
Name: wr_burst_packer

Overview:
- Parametrised write-side buffer that accepts a user write command (start address, length in beats) and a decoupled user data stream.
- Splits the transfer into AXI-legal bursts: at most BURST_LEN beats each, never crossing a 4 KB boundary, and a short final burst when the length is not a multiple of BURST_LEN.
- Issues one burst command plus its data beats per burst to the downstream AXI write master, using valid/ready handshakes on every interface.
- Sits between user logic and the AXI4 full write engine, in the same clock domain as the user logic.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 64, data beat width; power of two, 8..512.
- BURST_LEN, 256, maximum beats per burst; 1..256.
- FIFO_DEPTH, 4096, data FIFO depth in beats; power of two, at least BURST_LEN.
- LEN_W, 16, width of the command length field (beats).
- AF_MARGIN, 96, almost_full asserts when free entries are fewer than AF_MARGIN.

Ports:
- clk, in, 1, clock.
- resetn, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, user command valid.
- cmd_ready, out, 1, high when IDLE.
- cmd_addr, in, ADDR_W, start byte address; must be aligned to DATA_W/8.
- cmd_len, in, LEN_W, total beats.
- in_valid, in, 1, user data valid.
- in_ready, out, 1, high when the FIFO is not full.
- in_data, in, DATA_W, user data.
- bst_valid, out, 1, burst command valid.
- bst_ready, in, 1, burst command accepted.
- bst_addr, out, ADDR_W, burst start address.
- bst_len, out, 8, beats-1 (AXI AWLEN encoding).
- out_valid, out, 1, data beat valid.
- out_ready, in, 1, data beat accepted.
- out_data, out, DATA_W, data beat.
- out_last, out, 1, final beat of the burst.
- done, out, 1, one-cycle pulse when the command completes.
- busy, out, 1, high whenever the FSM is not IDLE.
- almost_full, out, 1, registered FIFO almost-full flag.
- level, out, log2(FIFO_DEPTH)+1, FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-low, clock clk): all outputs 0 except cmd_ready = 1 (asserted once out of reset); FIFO emptied; FSM in IDLE. Reset mid-transfer discards all state; no partial burst is completed.
- Data FIFO:
  - Synchronous, first-word-fall-through, FIFO_DEPTH x DATA_W.
  - Write occurs on in_valid && in_ready. Read occurs on out_valid && out_ready.
  - level updates one cycle after the handshake. A simultaneous read and write leaves level unchanged.
  - in_ready = (level != FIFO_DEPTH), combinational from the registered level.
  - Input is decoupled from commands: data may arrive before the command, and beats beyond cmd_len remain in the FIFO for the next command.
- FSM states: IDLE, CALC, WAIT_DATA, CMD, DATA, DONE.
- IDLE: on cmd_valid, latch the address into cur_addr and the length into rem (LEN_W bits), then go to CALC. If cmd_len == 0, go to DONE directly.
- CALC (1 cycle), burst size:
  - nb = min(rem, BURST_LEN, (4096 - cur_addr[11:0]) / (DATA_W/8)).
  - Compute in LEN_W+1 bits; nb is always >= 1.
  - Then go to WAIT_DATA.
- WAIT_DATA: stay until level >= nb (store-and-forward per burst, so the data phase never stalls on input), then go to CMD.
- CMD:
  - bst_valid = 1, bst_addr = cur_addr, bst_len = nb-1.
  - Outputs hold stable until bst_ready; then go to DATA.
- DATA:
  - out_valid = 1 while beat_cnt < nb; out_last = 1 when beat_cnt == nb-1.
  - beat_cnt increments on each out handshake.
  - On the last handshake: rem -= nb; cur_addr += nb*DATA_W/8 (wraps modulo 2^ADDR_W).
  - Then go to CALC if rem != 0, else DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- Latency, command accept to bst_valid: 3 cycles when data is already buffered (IDLE -> CALC -> WAIT_DATA -> CMD).
- Simultaneous events:
  - cmd_valid while not IDLE is ignored and cmd_ready stays 0.
  - A command with cmd_len > FIFO_DEPTH is legal, because bursts drain the FIFO progressively.
  - No burst command overlaps its data phase; exactly one burst is outstanding.
- almost_full: registered, = (FIFO_DEPTH - level) < AF_MARGIN.

Test Plan:
- Aligned transfer: cmd_addr=0x1000, cmd_len=512, 512 beats pre-loaded -> 2 bursts, (0x1000, len 255) and (0x1800, len 255); out_last on beats 256 and 512; done 1 cycle after the final beat.
- Short tail: cmd_addr=0, cmd_len=300 -> bursts (0x0, 255) and (0x800, 43); 300 beats output in order; level returns to 0.
- 4 KB split: cmd_addr=0x0F80, cmd_len=64, DATA_W=64 -> bursts (0x0F80, len 15) and (0x1000, len 47).
- Backpressure: bst_ready held low 10 cycles and out_ready toggled randomly -> bst_addr/bst_len stable throughout, no beat lost or duplicated, order preserved.
- Full/empty: 4096 beats written with no command -> in_ready = 0 and almost_full = 1 at level >= 4001; a cmd_len=4096 command then drains the FIFO in 16 bursts.
- Edge cases: cmd_len=0 -> done 1 cycle after accept with no bst_valid; resetn pulsed low mid-DATA -> all outputs 0 immediately, level = 0.
